muldiv_unit: RTL and testbench
==============================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have parameter CYCLES, default 32, number of iteration cycles (fixed at 32; other values unsupported).
REQ-002 SHALL have port clk  input  1  single system clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  request a new operation, sampled on clk rising edge.
REQ-005 SHALL have port op  input  2  operation: 00 MULT (signed), 01 MULTU, 10 DIV (signed), 11 DIVU.
REQ-006 SHALL have port in_a  input  32  multiplicand / dividend.
REQ-007 SHALL have port in_b  input  32  multiplier / divisor.
REQ-008 SHALL have port cancel  input  1  abort the in-flight operation (pipeline flush).
REQ-009 SHALL have port busy  output  1  operation in progress; new start ignored.
REQ-010 SHALL have port out_fg_write  output  1  one-cycle result-valid strobe, drives the HI/LO register write enable.
REQ-011 SHALL have port out_hi  output  32  product[63:32] or remainder.
REQ-012 SHALL have port out_lo  output  32  product[31:0] or quotient.

Function
REQ-013 SHALL implement states IDLE, CALC, FIX, DONE; busy=1 exactly in CALC and FIX.
REQ-014 SHALL, in IDLE or DONE with start=1 and cancel=0, latch op, |in_a| and |in_b| (signed ops; unsigned ops raw), the result sign flags, and enter CALC with count=0.
REQ-015 SHALL ignore start while busy=1; operands on in_a/in_b after the accept edge are don't-care.
REQ-016 SHALL perform one radix-2 step per CALC cycle: shift-add for multiply (64-bit accumulator), restoring shift-subtract for divide (33-bit partial remainder).
REQ-017 SHALL leave CALC after 32 steps (count 31->FIX), then apply sign correction in FIX and enter DONE.
REQ-018 SHALL assert out_fg_write=1 for exactly the single DONE cycle, i.e. 34 cycles after the accept edge; out_hi/out_lo update on the edge entering DONE.
REQ-019 SHALL hold out_hi/out_lo unchanged except on entering DONE; out_fg_write=0 in all other states.
REQ-020 SHALL return DONE->IDLE on the next edge unless a new start is accepted there (back-to-back, no idle bubble).
REQ-021 SHALL negate the product for MULT when sign(in_a) XOR sign(in_b)=1 (two's complement, 64-bit).
REQ-022 SHALL give DIV quotient sign = sign(a) XOR sign(b) and remainder sign = sign(a) (truncating division).
REQ-023 SHALL treat 0x80000000 magnitude as unsigned 2^31; DIV 0x80000000 / 0xFFFFFFFF yields lo=0x80000000, hi=0x00000000.
REQ-024 SHALL, for divisor 0 (any div op), complete with normal latency, lo=0xFFFFFFFF, hi=in_a; no exception raised.
REQ-025 SHALL, on cancel=1 in any state, go to IDLE on the next edge with no out_fg_write and out_hi/out_lo unchanged; cancel wins over simultaneous start.
REQ-026 SHALL produce no X on outputs for any op encoding or operand value.

Reset
REQ-027 SHALL, while rst=0, asynchronously force state=IDLE, count=0, busy=0, out_fg_write=0, out_hi=0x00000000, out_lo=0x00000000.
REQ-028 SHALL, on rst assertion mid-operation, discard the operation; first start after release is accepted normally.

Verification
REQ-029 SHALL pass: MULT in_a=0xFFFFFFFD, in_b=0x00000005 -> after 34 cycles out_fg_write pulse, hi=0xFFFFFFFF, lo=0xFFFFFFF1.
REQ-030 SHALL pass: MULTU 0xFFFFFFFF x 0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001; busy high 33 cycles.
REQ-031 SHALL pass: DIV 0xFFFFFFF9 / 0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; then DIVU 100/7 started in the DONE cycle -> lo=0x0000000E, hi=0x00000002, 34 cycles later.
REQ-032 SHALL pass: DIVU 0x12345678 / 0 -> lo=0xFFFFFFFF, hi=0x12345678; DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 SHALL pass: cancel at CALC step 10 -> IDLE next edge, no out_fg_write, outputs hold prior result; start while busy -> ignored, original result unchanged.
REQ-034 SHALL pass: rst low at CALC step 20 -> busy, out_fg_write, out_hi, out_lo immediately 0 without a clock edge; post-release MULTU 3x4 -> lo=0x0000000C, hi=0.

Source files
------------

// File: rtl/muldiv_unit.sv
// muldiv_unit -- iterative 32x32 multiply / divide unit (radix-2, one step per cycle).
//
// Ports:
//   clk           rising-edge system clock
//   rst           asynchronous active-low reset
//   start         request a new operation (accepted in IDLE or DONE)
//   op[1:0]       00 MULT, 01 MULTU, 10 DIV, 11 DIVU
//   in_a, in_b    multiplicand/dividend, multiplier/divisor (sampled on accept edge only)
//   cancel        abort whatever is in flight; wins over start
//   busy          high while iterating (CALC) and during sign fix-up (FIX)
//   out_fg_write  one-cycle strobe in DONE, HI/LO register write enable
//   out_hi/out_lo product[63:32]/[31:0], or remainder/quotient
//
// Timing: accept edge -> 32 CALC cycles -> 1 FIX cycle -> DONE (34th cycle after accept).
module muldiv_unit #(
    parameter int CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] in_a,
    input  logic [31:0] in_b,
    input  logic        cancel,
    output logic        busy,
    output logic        out_fg_write,
    output logic [31:0] out_hi,
    output logic [31:0] out_lo
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state;
    logic [4:0]  count;
    logic        is_div;
    logic        neg_lo;     // negate product (mul) or quotient (div)
    logic        neg_hi;     // negate remainder (div)
    logic [31:0] acc_hi;     // product upper half / partial remainder
    logic [31:0] acc_lo;     // multiplier shifting out / dividend-quotient shifting
    logic [31:0] divisor;    // |b| for both mul and div

    // Operand magnitudes; unsigned ops (op[0]=1) pass raw values.
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    assign a_neg = ~op[0] & in_a[31];
    assign b_neg = ~op[0] & in_b[31];
    assign a_mag = a_neg ? (~in_a + 32'd1) : in_a;
    assign b_mag = b_neg ? (~in_b + 32'd1) : in_b;

    // Multiply step: add multiplicand to upper half when LSB of multiplier set,
    // then shift the whole 65-bit {carry, acc_hi, acc_lo} right by one.
    logic [32:0] mul_sum;
    assign mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, divisor} : 33'd0);

    // Divide step: restoring; 33-bit partial remainder after the left shift.
    logic [32:0] div_shift, div_diff;
    logic        div_ge;
    assign div_shift = {acc_hi, acc_lo[31]};
    assign div_ge    = div_shift >= {1'b0, divisor};
    assign div_diff  = div_shift - {1'b0, divisor};

    // Sign fix-up values consumed on the FIX -> DONE edge.
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;
    assign prod_fix = neg_lo ? (~{acc_hi, acc_lo} + 64'd1) : {acc_hi, acc_lo};
    assign quo_fix  = neg_lo ? (~acc_lo + 32'd1) : acc_lo;
    assign rem_fix  = neg_hi ? (~acc_hi + 32'd1) : acc_hi;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            count        <= 5'd0;
            busy         <= 1'b0;
            out_fg_write <= 1'b0;
            out_hi       <= 32'd0;
            out_lo       <= 32'd0;
            is_div       <= 1'b0;
            neg_lo       <= 1'b0;
            neg_hi       <= 1'b0;
            acc_hi       <= 32'd0;
            acc_lo       <= 32'd0;
            divisor      <= 32'd0;
        end else if (cancel) begin
            state        <= IDLE;
            count        <= 5'd0;
            busy         <= 1'b0;
            out_fg_write <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    out_fg_write <= 1'b0;
                    if (start) begin
                        state   <= CALC;
                        count   <= 5'd0;
                        busy    <= 1'b1;
                        is_div  <= op[1];
                        // Divide-by-zero keeps quotient all-ones: no quotient negation.
                        neg_lo  <= (a_neg ^ b_neg) & (~op[1] | (in_b != 32'd0));
                        neg_hi  <= a_neg;
                        acc_hi  <= 32'd0;
                        acc_lo  <= a_mag;
                        divisor <= b_mag;
                    end else begin
                        state <= IDLE;
                    end
                end
                CALC: begin
                    if (is_div) begin
                        acc_hi <= div_ge ? div_diff[31:0] : div_shift[31:0];
                        acc_lo <= {acc_lo[30:0], div_ge};
                    end else begin
                        acc_hi <= mul_sum[32:1];
                        acc_lo <= {mul_sum[0], acc_lo[31:1]};
                    end
                    count <= count + 5'd1;
                    if (count == 5'(CYCLES - 1))
                        state <= FIX;
                end
                FIX: begin
                    state        <= DONE;
                    busy         <= 1'b0;
                    out_fg_write <= 1'b1;
                    if (is_div) begin
                        out_hi <= rem_fix;
                        out_lo <= quo_fix;
                    end else begin
                        out_hi <= prod_fix[63:32];
                        out_lo <= prod_fix[31:0];
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases plus random ops against
// a plain-arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] in_a = 32'd0;
    logic [31:0] in_b = 32'd0;
    logic        cancel = 1'b0;
    logic        busy, out_fg_write;
    logic [31:0] out_hi, out_lo;

    int total = 0;
    int bad = 0;
    logic [31:0] prev_hi = 32'd0, prev_lo = 32'd0;

    muldiv_unit #(.CYCLES(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .in_a(in_a), .in_b(in_b),
        .cancel(cancel), .busy(busy), .out_fg_write(out_fg_write),
        .out_hi(out_hi), .out_lo(out_lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: 64-bit arithmetic straight from the operation definitions.
    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] hi, output logic [31:0] lo);
        logic [63:0] p, q, r;
        longint sa, sb;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p = 64'd0; q = 64'd0; r = 64'd0;
        case (o)
            2'b00: p = sa * sb;
            2'b01: p = {32'd0, a} * {32'd0, b};
            2'b10: if (b != 0) begin q = sa / sb; r = sa % sb; end
            default: if (b != 0) begin q = {32'd0, a} / {32'd0, b}; r = {32'd0, a} % {32'd0, b}; end
        endcase
        if (o[1] == 1'b0) begin
            hi = p[63:32]; lo = p[31:0];
        end else if (b == 0) begin
            hi = a; lo = 32'hFFFF_FFFF;
        end else begin
            hi = r[31:0]; lo = q[31:0];
        end
    endfunction

    // Called mid-cycle with DUT in IDLE or DONE; returns mid-cycle 1 (first CALC cycle).
    task automatic accept(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1; op = o; in_a = a; in_b = b;
        @(posedge clk); #1;
        start = 1'b0; in_a = $urandom; in_b = $urandom;
    endtask

    // Walk cycles 1..33 (busy, no strobe, outputs held), optionally poking start
    // at cycle 'poke', then check the DONE cycle (34th).
    task automatic finish_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                             input logic [31:0] b, input int poke);
        logic [31:0] ehi, elo;
        bit ok = 1'b1;
        model(o, a, b, ehi, elo);
        for (int i = 1; i <= 33; i++) begin
            if (!(busy === 1'b1 && out_fg_write === 1'b0 && out_hi === prev_hi && out_lo === prev_lo))
                ok = 1'b0;
            if (i == poke) begin
                start = 1'b1; op = ~o; in_a = $urandom; in_b = $urandom;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        chk({tag, "_busy33"}, {63'd0, ok}, 64'd1);
        chk({tag, "_done"}, {62'd0, out_fg_write, busy}, {62'd0, 2'b10});
        chk({tag, "_result"}, {out_hi, out_lo}, {ehi, elo});
        prev_hi = ehi; prev_lo = elo;
    endtask

    task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        accept(o, a, b);
        finish_op(tag, o, a, b, 0);
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
    endtask

    initial begin
        logic [1:0] ro;
        logic [31:0] ra, rb;
        bit ok;

        // Reset state
        #2;
        chk("reset_outputs", {30'd0, busy, out_fg_write, out_hi ^ out_lo}, 64'd0);
        chk("reset_hilo", {out_hi, out_lo}, 64'd0);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;

        // Directed cases
        run_op("mult_neg", 2'b00, 32'hFFFF_FFFD, 32'h0000_0005);
        idle_cycle();
        chk("done_to_idle", {62'd0, busy, out_fg_write}, 64'd0);
        run_op("multu_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        idle_cycle();
        run_op("div_neg", 2'b10, 32'hFFFF_FFF9, 32'h0000_0002);
        // Back-to-back: start in the DONE cycle
        run_op("divu_b2b", 2'b11, 32'd100, 32'd7);
        idle_cycle();
        run_op("divu_zero", 2'b11, 32'h1234_5678, 32'h0000_0000);
        idle_cycle();
        run_op("div_zero_neg", 2'b10, 32'h8000_0005, 32'h0000_0000);
        idle_cycle();
        run_op("div_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        idle_cycle();
        run_op("mult_minmin", 2'b00, 32'h8000_0000, 32'h8000_0000);
        idle_cycle();

        // Start while busy is ignored
        accept(2'b01, 32'h0001_0003, 32'h0000_0007);
        finish_op("start_busy", 2'b01, 32'h0001_0003, 32'h0000_0007, 5);
        idle_cycle();

        // Cancel at CALC step 10
        accept(2'b00, 32'h0000_1234, 32'h0000_5678);
        for (int i = 1; i <= 10; i++) idle_cycle();
        cancel = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        cancel = 1'b0; start = 1'b0;
        chk("cancel_idle", {62'd0, busy, out_fg_write}, 64'd0);
        chk("cancel_hold", {out_hi, out_lo}, {prev_hi, prev_lo});
        ok = 1'b1;
        for (int i = 0; i < 40; i++) begin
            if (busy !== 1'b0 || out_fg_write !== 1'b0 || out_hi !== prev_hi || out_lo !== prev_lo) ok = 1'b0;
            idle_cycle();
        end
        chk("cancel_quiet", {63'd0, ok}, 64'd1);

        // Random ops, some back-to-back
        for (int n = 0; n < 12; n++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 5))
                0: rb = 32'd0;
                1: rb = 32'($urandom_range(1, 9));
                2: ra = 32'h8000_0000;
                default: ;
            endcase
            run_op($sformatf("rand%0d_op%0d", n, ro), ro, ra, rb);
            if ($urandom_range(0, 1) == 0) idle_cycle();
        end
        idle_cycle();

        // Asynchronous reset mid-operation
        accept(2'b00, 32'h7654_3210, 32'h0123_4567);
        for (int i = 1; i <= 20; i++) idle_cycle();
        rst = 1'b0;
        #1;
        chk("async_rst", {30'd0, busy, out_fg_write, 32'd0}, 64'd0);
        chk("async_rst_hilo", {out_hi, out_lo}, 64'd0);
        prev_hi = 32'd0; prev_lo = 32'd0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        run_op("post_rst_multu", 2'b01, 32'd3, 32'd4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
